// File: rtl/param_bcd_formatter_if.sv
// param_bcd_formatter_if: measurement inputs, control and formatted BCD results
interface param_bcd_formatter_if;
  logic [15:0] freq_in;
  logic [15:0] amplitude_in;
  logic [15:0] duty_in;
  logic [15:0] thd_in;
  logic start;
  logic auto_en;
  logic [19:0] freq_bcd;
  logic [19:0] amp_bcd;
  logic [19:0] duty_bcd;
  logic [19:0] thd_bcd;
  logic [2:0] freq_ndig;
  logic [2:0] amp_ndig;
  logic [2:0] duty_ndig;
  logic [2:0] thd_ndig;
  logic busy;
  logic done;
  modport master (
    output freq_in, amplitude_in, duty_in, thd_in, start, auto_en,
    input freq_bcd, amp_bcd, duty_bcd, thd_bcd,
    input freq_ndig, amp_ndig, duty_ndig, thd_ndig, busy, done
  );
  modport slave (
    input freq_in, amplitude_in, duty_in, thd_in, start, auto_en,
    output freq_bcd, amp_bcd, duty_bcd, thd_bcd,
    output freq_ndig, amp_ndig, duty_ndig, thd_ndig, busy, done
  );
endinterface

// File: rtl/param_bcd_formatter.sv
// param_bcd_formatter: snapshots four 16-bit results and publishes them atomically as 5-digit BCD
module param_bcd_formatter #(
  parameter int unsigned REFRESH_DIV = 10_000_000
) (
  input logic clk,
  input logic rst_n,
  param_bcd_formatter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;
  state_t state, state_d;
  logic [31:0] rcnt;
  logic tick, trig, pending, done;
  logic [1:0] idx;
  logic [3:0] scnt;
  logic [35:0] sr, adj;
  logic [2:0] nd;
  logic [15:0] snap [4];
  logic [19:0] sh_bcd [4];
  logic [19:0] out_bcd [4];
  logic [2:0] sh_nd [4];
  logic [2:0] out_nd [4];
  assign tick = bus.auto_en && rcnt == REFRESH_DIV - 1;
  assign trig = bus.start | tick;
  assign nd = |sr[35:32] ? 3'd5 : |sr[31:28] ? 3'd4 : |sr[27:24] ? 3'd3 : |sr[23:20] ? 3'd2 : 3'd1;
  always_comb begin
    adj = sr;
    for (int i = 0; i < 5; i++)
      adj[16 + 4*i +: 4] = sr[16 + 4*i +: 4] >= 4'd5 ? sr[16 + 4*i +: 4] + 4'd3 : sr[16 + 4*i +: 4];
  end
  always_comb begin
    state_d = state;
    state_d = state == IDLE  ? ((trig || pending) ? LOAD : IDLE) :
              state == LOAD  ? SHIFT :
              state == SHIFT ? (scnt == 4'd15 ? STORE : SHIFT) :
              idx == 2'd3    ? IDLE : LOAD;
  end
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_d;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rcnt <= '0;
      pending <= 1'b0;
      done <= 1'b0;
      idx <= '0;
      scnt <= '0;
      sr <= '0;
      for (int i = 0; i < 4; i++) begin
        snap[i] <= '0;
        sh_bcd[i] <= '0;
        out_bcd[i] <= '0;
        sh_nd[i] <= 3'd1;
        out_nd[i] <= 3'd1;
      end
    end else begin
      rcnt <= (tick || !bus.auto_en) ? '0 : rcnt + 32'd1;
      done <= 1'b0;
      if (state != IDLE && trig)
        pending <= 1'b1;
      if (state == IDLE && (trig || pending)) begin
        snap[0] <= bus.freq_in;
        snap[1] <= bus.amplitude_in;
        snap[2] <= bus.duty_in;
        snap[3] <= bus.thd_in;
        pending <= 1'b0;
        idx <= '0;
      end
      if (state == LOAD) begin
        sr <= {20'b0, snap[idx]};
        scnt <= '0;
      end
      if (state == SHIFT) begin
        sr <= adj << 1;
        scnt <= scnt + 4'd1;
      end
      if (state == STORE) begin
        sh_bcd[idx] <= sr[35:16];
        sh_nd[idx] <= nd;
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          for (int i = 0; i < 3; i++) begin
            out_bcd[i] <= sh_bcd[i];
            out_nd[i] <= sh_nd[i];
          end
          out_bcd[3] <= sr[35:16];
          out_nd[3] <= nd;
          done <= 1'b1;
        end
      end
    end
  end
  assign bus.freq_bcd = out_bcd[0];
  assign bus.amp_bcd = out_bcd[1];
  assign bus.duty_bcd = out_bcd[2];
  assign bus.thd_bcd = out_bcd[3];
  assign bus.freq_ndig = out_nd[0];
  assign bus.amp_ndig = out_nd[1];
  assign bus.duty_ndig = out_nd[2];
  assign bus.thd_ndig = out_nd[3];
  assign bus.busy = state != IDLE;
  assign bus.done = done;
endmodule

// File: tb/tb_param_bcd_formatter.sv
// tb_param_bcd_formatter: directed and randomized checks against a decimal-arithmetic model
module tb_param_bcd_formatter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  param_bcd_formatter_if bus();
  param_bcd_formatter #(.REFRESH_DIV(100)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int e0 = 0;
  int lat;
  int cnt;
  logic [15:0] sv [4];
  logic [15:0] bnd [12];
  int dq [$];
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [19:0] to_bcd(input logic [15:0] v);
    logic [19:0] r;
    int x;
    r = '0;
    x = int'(v);
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction
  function automatic logic [2:0] nd_of(input logic [15:0] v);
    return v >= 10000 ? 3'd5 : v >= 1000 ? 3'd4 : v >= 100 ? 3'd3 : v >= 10 ? 3'd2 : 3'd1;
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic start_conv;
    sv[0] = bus.freq_in;
    sv[1] = bus.amplitude_in;
    sv[2] = bus.duty_in;
    sv[3] = bus.thd_in;
    bus.start = 1'b1;
    tick_n(1);
    bus.start = 1'b0;
    e0 = cyc;
    check("busy_after_accept", 32'(bus.busy), 1);
  endtask
  task automatic wait_done;
    lat = -1;
    for (int k = 0; k < 300 && lat < 0; k++) begin
      tick_n(1);
      if (bus.done) lat = cyc - e0;
    end
    check("latency", lat, 72);
  endtask
  task automatic count_done(input int n, output int c);
    c = 0;
    repeat (n) begin
      tick_n(1);
      if (bus.done) c++;
    end
  endtask
  task automatic check_all;
    check("freq_bcd", 32'(bus.freq_bcd), 32'(to_bcd(sv[0])));
    check("amp_bcd", 32'(bus.amp_bcd), 32'(to_bcd(sv[1])));
    check("duty_bcd", 32'(bus.duty_bcd), 32'(to_bcd(sv[2])));
    check("thd_bcd", 32'(bus.thd_bcd), 32'(to_bcd(sv[3])));
    check("freq_ndig", 32'(bus.freq_ndig), 32'(nd_of(sv[0])));
    check("amp_ndig", 32'(bus.amp_ndig), 32'(nd_of(sv[1])));
    check("duty_ndig", 32'(bus.duty_ndig), 32'(nd_of(sv[2])));
    check("thd_ndig", 32'(bus.thd_ndig), 32'(nd_of(sv[3])));
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_bcd_or"}, 32'(bus.freq_bcd | bus.amp_bcd | bus.duty_bcd | bus.thd_bcd), 0);
    check({tag, "_ndig"}, 32'({bus.freq_ndig, bus.amp_ndig, bus.duty_ndig, bus.thd_ndig}), 32'h249);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
  endtask
  initial begin
    bnd = '{16'd9, 16'd10, 16'd99, 16'd100, 16'd999, 16'd1000, 16'd9999, 16'd10000, 16'd0, 16'd65535, 16'd1, 16'd65534};
    bus.freq_in = '0;
    bus.amplitude_in = '0;
    bus.duty_in = '0;
    bus.thd_in = '0;
    bus.start = 1'b0;
    bus.auto_en = 1'b0;
    tick_n(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick_n(2);
    bus.freq_in = 16'd1000;
    bus.amplitude_in = 16'd255;
    bus.duty_in = 16'd0;
    bus.thd_in = 16'd65535;
    start_conv();
    tick_n(71);
    check("busy_e71", 32'(bus.busy), 1);
    check("done_early", 32'(bus.done), 0);
    wait_done();
    check("basic_freq", 32'(bus.freq_bcd), 32'h01000);
    check("basic_freq_nd", 32'(bus.freq_ndig), 4);
    check("basic_amp", 32'(bus.amp_bcd), 32'h00255);
    check("basic_amp_nd", 32'(bus.amp_ndig), 3);
    check("basic_duty", 32'(bus.duty_bcd), 32'h00000);
    check("basic_duty_nd", 32'(bus.duty_ndig), 1);
    check("basic_thd", 32'(bus.thd_bcd), 32'h65535);
    check("basic_thd_nd", 32'(bus.thd_ndig), 5);
    check("busy_after_commit", 32'(bus.busy), 0);
    tick_n(1);
    check("done_one_cycle", 32'(bus.done), 0);
    bus.freq_in = 16'd500;
    start_conv();
    tick_n(5);
    bus.freq_in = 16'd9999;
    wait_done();
    check("snap_freq", 32'(bus.freq_bcd), 32'h00500);
    tick_n(1);
    start_conv();
    wait_done();
    check("snap_freq2", 32'(bus.freq_bcd), 32'h09999);
    tick_n(1);
    bus.duty_in = 16'd750;
    start_conv();
    tick_n(30);
    bus.duty_in = 16'd999;
    bus.start = 1'b1;
    tick_n(1);
    bus.start = 1'b0;
    tick_n(1);
    bus.start = 1'b1;
    tick_n(1);
    bus.start = 1'b0;
    wait_done();
    check("pend_first_duty", 32'(bus.duty_bcd), 32'h00750);
    check_all();
    tick_n(1);
    check("pend_busy_again", 32'(bus.busy), 1);
    e0 = cyc;
    sv[2] = 16'd999;
    wait_done();
    check("pend_second_duty", 32'(bus.duty_bcd), 32'h00999);
    check("pend_second_nd", 32'(bus.duty_ndig), 3);
    count_done(150, cnt);
    check("pend_no_extra_done", cnt, 0);
    bus.freq_in = 16'd4321;
    start_conv();
    tick_n(40);
    rst_n = 1'b0;
    tick_n(1);
    rst_n = 1'b1;
    check_reset_outputs("midrst");
    count_done(150, cnt);
    check("midrst_no_done", cnt, 0);
    bus.freq_in = 16'($urandom);
    bus.amplitude_in = 16'($urandom);
    bus.duty_in = 16'($urandom_range(0, 1000));
    bus.thd_in = 16'($urandom_range(0, 1000));
    sv[0] = bus.freq_in;
    sv[1] = bus.amplitude_in;
    sv[2] = bus.duty_in;
    sv[3] = bus.thd_in;
    bus.auto_en = 1'b1;
    repeat (400) begin
      tick_n(1);
      if (bus.done) dq.push_back(cyc);
    end
    check("auto_count", dq.size(), 3);
    if (dq.size() >= 3) begin
      check("auto_period1", dq[1] - dq[0], 100);
      check("auto_period2", dq[2] - dq[1], 100);
    end
    check_all();
    cnt = 0;
    while (!bus.busy && cnt < 150) begin
      tick_n(1);
      cnt++;
    end
    check("auto_busy_seen", 32'(bus.busy), 1);
    bus.auto_en = 1'b0;
    count_done(250, cnt);
    check("auto_inflight_done", cnt, 1);
    for (int n = 0; n < 500; n++) begin
      if (n < 12) begin
        bus.freq_in = bnd[n];
        bus.amplitude_in = bnd[(n + 3) % 12];
        bus.duty_in = bnd[(n + 6) % 12];
        bus.thd_in = bnd[(n + 9) % 12];
      end else begin
        bus.freq_in = 16'($urandom);
        bus.amplitude_in = 16'($urandom);
        bus.duty_in = 16'($urandom);
        bus.thd_in = 16'($urandom);
      end
      start_conv();
      bus.freq_in = 16'($urandom);
      bus.thd_in = 16'($urandom);
      wait_done();
      check_all();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
